down_counter: RTL and testbench

Loadable down-counting timer that counts a programmed value toward zero on the falling clock edge and signals completion with a one-cycle `done` pulse. It sits beside the free-running 4-bit up-counter in the DFF/counter library and is used wherever a fixed number of cycles must elapse before an event fires. Its `hold` input gates counting and pairs naturally with the up-counter's `control` input in small timing chains.

---
 rtl/down_counter.sv | 102 ++++++++++
 tb/tb_down_counter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/down_counter.sv
// Loadable down-counting timer: counts a loaded value to zero on the falling clock edge and pulses done for one cycle.
// Optional DOWN_COUNTER_AUTO_RELOAD_EN restarts the count from the last loaded value after each done pulse.
module down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             hold,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             busy_q;
  logic             done_q;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    case (state_q)
      IDLE: begin
        // load wins over start on the same edge
        if (load) begin
          count_d  = load_val;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
          reload_d = load_val;
`endif
        end else if (start) begin
          state_d = (count_q == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (!hold) begin
          count_d = count_q - WIDTH'(1);
          if (count_q == WIDTH'(1)) state_d = DONE;
        end
      end
      DONE: begin
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        if (reload_q != '0) begin
          count_d = reload_q;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(negedge clk) begin
    if (!nrst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == DONE);
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign zero  = (count_q == '0);

endmodule

// File: tb/tb_down_counter.sv
// Scoreboard bench for down_counter: directed steps push expected outputs, a monitor pops and compares each cycle.
module tb_down_counter;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             nrst = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic             start = 1'b0;
  logic             hold = 1'b0;
  logic             stop = 1'b0;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             zero;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] cnt;
    logic             bsy;
    logic             dn;
    logic             zr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  down_counter #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .hold     (hold),
    .stop     (stop),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  // State changes on negedge; the monitor samples on the following posedge.
  initial begin
    forever begin
      @(posedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        n_checks++;
        if (count === e.cnt && busy === e.bsy && done === e.dn && zero === e.zr) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got count=%0d busy=%b done=%b zero=%b, want count=%0d busy=%b done=%b zero=%b",
                   e.name, count, busy, done, zero, e.cnt, e.bsy, e.dn, e.zr);
        end
      end
    end
  end

  task automatic step(input string nm, input logic n, input logic ld, input logic [WIDTH-1:0] lv,
                      input logic st, input logic hd, input logic sp,
                      input logic [WIDTH-1:0] ec, input logic eb, input logic ed);
    exp_t e;
    @(posedge clk);
    #1;
    nrst = n; load = ld; load_val = lv; start = st; hold = hd; stop = sp;
    e.name = nm; e.cnt = ec; e.bsy = eb; e.dn = ed; e.zr = (ec == '0);
    exp_q.push_back(e);
  endtask

  task automatic idle(input string nm, input logic [WIDTH-1:0] ec);
    step(nm, 1, 0, '0, 0, 0, 0, ec, 0, 0);
  endtask

  // Edge after DONE: IDLE, or with auto-reload a restart from the reload value (then stopped).
  task automatic after_done(input string nm, input logic [WIDTH-1:0] r);
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    if (r != '0) begin
      step(nm, 1, 0, '0, 0, 0, 0, r, 1, 0);
      step({nm, "_stop"}, 1, 0, '0, 0, 0, 1, r, 0, 0);
    end else begin
      idle(nm, '0);
    end
`else
    idle(nm, '0);
`endif
  endtask

  initial begin
    // reset with random inputs
    for (int i = 0; i < 2; i++)
      step("reset", 0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, 0);

    // basic count from 5
    step("b_load", 1, 1, 5, 0, 0, 0, 5, 0, 0);
    step("b_start", 1, 0, 0, 1, 0, 0, 5, 1, 0);
    step("b_4", 1, 0, 0, 0, 0, 0, 4, 1, 0);
    step("b_3", 1, 0, 0, 0, 0, 0, 3, 1, 0);
    step("b_2", 1, 0, 0, 0, 0, 0, 2, 1, 0);
    step("b_1", 1, 0, 0, 0, 0, 0, 1, 1, 0);
    step("b_done", 1, 0, 0, 0, 0, 0, 0, 1, 1);
    after_done("b_after", 5);

    // hold for 3 cycles after first decrement
    step("h_load", 1, 1, 4, 0, 0, 0, 4, 0, 0);
    step("h_start", 1, 0, 0, 1, 0, 0, 4, 1, 0);
    step("h_3", 1, 0, 0, 0, 0, 0, 3, 1, 0);
    for (int i = 0; i < 3; i++) step("h_hold", 1, 0, 0, 0, 1, 0, 3, 1, 0);
    step("h_2", 1, 0, 0, 0, 0, 0, 2, 1, 0);
    step("h_1", 1, 0, 0, 0, 0, 0, 1, 1, 0);
    step("h_done", 1, 0, 0, 0, 0, 0, 0, 1, 1);
    after_done("h_after", 4);

    // stop at count 2
    step("s_load", 1, 1, 4, 0, 0, 0, 4, 0, 0);
    step("s_start", 1, 0, 0, 1, 0, 0, 4, 1, 0);
    step("s_3", 1, 0, 0, 0, 0, 0, 3, 1, 0);
    step("s_2", 1, 0, 0, 0, 0, 0, 2, 1, 0);
    step("s_stop", 1, 0, 0, 0, 0, 1, 2, 0, 0);
    for (int i = 0; i < 3; i++) idle("s_idle", 2);

    // load 0 then start: done on the next edge
    step("z_load", 1, 1, 0, 0, 0, 0, 0, 0, 0);
    step("z_start", 1, 0, 0, 1, 0, 0, 0, 1, 1);
    after_done("z_after", 0);

    // load max: 15 decrements, no wrap
    step("m_load", 1, 1, 15, 0, 0, 0, 15, 0, 0);
    step("m_start", 1, 0, 0, 1, 0, 0, 15, 1, 0);
    for (int i = 14; i >= 1; i--) step("m_dec", 1, 0, 0, 0, 0, 0, 4'(i), 1, 0);
    step("m_done", 1, 0, 0, 0, 0, 0, 0, 1, 1);
    after_done("m_after", 15);

    // load and start together: loaded, stays IDLE
    step("ls_both", 1, 1, 7, 1, 0, 0, 7, 0, 0);
    idle("ls_idle", 7);

    // load during RUN is ignored
    step("lr_start", 1, 0, 0, 1, 0, 0, 7, 1, 0);
    step("lr_load", 1, 1, 2, 0, 0, 0, 6, 1, 0);
    step("lr_stop", 1, 0, 0, 0, 0, 1, 6, 0, 0);

    // reset mid-RUN at count 3
    step("r_load", 1, 1, 5, 0, 0, 0, 5, 0, 0);
    step("r_start", 1, 0, 0, 1, 0, 0, 5, 1, 0);
    step("r_4", 1, 0, 0, 0, 0, 0, 4, 1, 0);
    step("r_3", 1, 0, 0, 0, 0, 0, 3, 1, 0);
    step("r_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) idle("r_idle", 0);

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    // periodic done every 4 cycles from reload 3
    step("a_load", 1, 1, 3, 0, 0, 0, 3, 0, 0);
    step("a_start", 1, 0, 0, 1, 0, 0, 3, 1, 0);
    step("a_2", 1, 0, 0, 0, 0, 0, 2, 1, 0);
    step("a_1", 1, 0, 0, 0, 0, 0, 1, 1, 0);
    step("a_done", 1, 0, 0, 0, 0, 0, 0, 1, 1);
    for (int p = 0; p < 3; p++) begin
      step("a_rl", 1, 0, 0, 0, 0, 0, 3, 1, 0);
      step("a_2", 1, 0, 0, 0, 0, 0, 2, 1, 0);
      step("a_1", 1, 0, 0, 0, 0, 0, 1, 1, 0);
      step("a_done", 1, 0, 0, 0, 0, 0, 0, 1, 1);
    end
    step("a_rl", 1, 0, 0, 0, 0, 0, 3, 1, 0);
    step("a_stop", 1, 0, 0, 0, 0, 1, 3, 0, 0);
    for (int i = 0; i < 5; i++) idle("a_idle", 3);
`endif

    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expected responses left, want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached, want bench to finish");
    $fatal(1, "timeout");
  end

endmodule
